// File: rtl/alu_execute_unit.sv
// alu_execute_unit
//   Execute-stage ALU. Accepts an aluControl code plus two operands through a
//   valid/ready handshake and returns a registered result and zero flag through
//   a second valid/ready handshake. add/sub/and/or/sltu/slt complete in one
//   cycle; sll/srl either run on an iterative one-bit-per-cycle shifter
//   (default) or on a single-cycle barrel shifter.
//
//   Build option:
//     ALU_FAST_SHIFT_EN  defined   -> barrel shifter, every op has 1-cycle latency,
//                                     no SHIFT state or counter.
//                        undefined -> iterative shifter, shamt k costs 1+k cycles.
//
//   Ports:
//     clk        in   clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     inValid    in   operands / aluControl valid
//     inReady    out  operation accepted this cycle when inValid is also high
//     aluControl in   000 add, 001 sub, 010 and, 011 or, 100 sltu, 101 slt,
//                     110 sll, 111 srl
//     srcA       in   operand A (value shifted for sll/srl)
//     srcB       in   operand B (only [SHAMT_W-1:0] used for shifts)
//     outValid   out  aluResult / zero valid
//     outReady   in   downstream consumes the result
//     aluResult  out  registered result
//     zero       out  registered, 1 iff aluResult == 0
module alu_execute_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [2:0]            aluControl,
  input  logic [DATA_WIDTH-1:0] srcA,
  input  logic [DATA_WIDTH-1:0] srcB,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] aluResult,
  output logic                  zero
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_SLTU = 3'b100,
    OP_SLT  = 3'b101,
    OP_SLL  = 3'b110,
    OP_SRL  = 3'b111
  } alu_op_e;

`ifdef ALU_FAST_SHIFT_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;
`endif

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d;
  logic [DATA_WIDTH-1:0] alu_out;
  logic [SHAMT_W-1:0]    shamt;
  logic                  accept;
  alu_op_e               op;

`ifndef ALU_FAST_SHIFT_EN
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [SHAMT_W-1:0]    cnt_q, cnt_d;
  logic                  dir_q, dir_d;   // 1 = logical right, 0 = left
  logic [DATA_WIDTH-1:0] shifted;
  logic                  is_shift;
`endif

  assign op    = alu_op_e'(aluControl);
  assign shamt = srcB[SHAMT_W-1:0];

`ifdef ALU_FAST_SHIFT_EN
  assign inReady = (state_q == IDLE) | outReady;
`else
  assign inReady  = (state_q == IDLE) | ((state_q == DONE) & outReady);
  assign is_shift = (aluControl[2:1] == 2'b11);
`endif

  assign accept    = inValid & inReady;
  assign outValid  = (state_q == DONE);
  assign aluResult = result_q;
  assign zero      = zero_q;

  // Single-cycle datapath. In the iterative build the shift entries only
  // serve the shamt==0 case, where the result is srcA unchanged.
  always_comb begin
    alu_out = '0;
    unique case (op)
      OP_ADD:  alu_out = srcA + srcB;
      OP_SUB:  alu_out = srcA - srcB;
      OP_AND:  alu_out = srcA & srcB;
      OP_OR:   alu_out = srcA | srcB;
      OP_SLTU: alu_out = {{(DATA_WIDTH-1){1'b0}}, (srcA < srcB)};
      OP_SLT:  alu_out = {{(DATA_WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL:  alu_out = srcA << shamt;
      OP_SRL:  alu_out = srcA >> shamt;
`else
      OP_SLL:  alu_out = srcA;
      OP_SRL:  alu_out = srcA;
`endif
      default: alu_out = '0;
    endcase
  end

`ifndef ALU_FAST_SHIFT_EN
  always_comb begin
    shifted = dir_q ? (shreg_q >> 1) : (shreg_q << 1);
  end
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifndef ALU_FAST_SHIFT_EN
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
`endif
    unique case (state_q)
`ifndef ALU_FAST_SHIFT_EN
      SHIFT: begin
        shreg_d = shifted;
        cnt_d   = cnt_q - SHAMT_W'(1);
        // Last step: the shifted value goes straight into the result so
        // DONE is entered on the same edge as the final shift.
        if (cnt_q == SHAMT_W'(1)) begin
          result_d = shifted;
          zero_d   = (shifted == '0);
          state_d  = DONE;
        end
      end
`endif
      default: begin
        // IDLE and DONE share the accept path so a DONE/outReady/accept cycle
        // starts the next op with no bubble.
        if (accept) begin
`ifndef ALU_FAST_SHIFT_EN
          if (is_shift) begin
            shreg_d = srcA;
            cnt_d   = shamt;
            dir_d   = aluControl[0];
          end
          if (is_shift && (shamt != '0)) begin
            state_d = SHIFT;
          end else begin
            result_d = alu_out;
            zero_d   = (alu_out == '0);
            state_d  = DONE;
          end
`else
          result_d = alu_out;
          zero_d   = (alu_out == '0);
          state_d  = DONE;
`endif
        end else if ((state_q == DONE) && outReady) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

`ifndef ALU_FAST_SHIFT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end
`endif

endmodule

// File: doc/alu_execute_unit.md
# alu_execute_unit

Execute-stage ALU of the RISC-V core, directly downstream of the ALU decoder: it consumes the 3-bit `aluControl` code plus two operands and produces a registered result and zero flag. Add/sub/logic/compare complete in one cycle; shifts run on an iterative one-bit-per-cycle shifter, with a `valid`/`ready` handshake on both sides so the stage can stall the decoder and be back-pressured by writeback.

## Interface
- `DATA_WIDTH`, default 32: operand/result width, power of two, ≥ 8.
- `SHAMT_W`, default `$clog2(DATA_WIDTH)`: shift-amount width; derived, not overridden.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `inValid` in 1: operands and `aluControl` valid.
- `inReady` out 1: unit accepts an operation this cycle.
- `aluControl` in 3: 000 add, 001 sub, 010 and, 011 or, 100 sltu, 101 slt, 110 sll, 111 srl.
- `srcA` in `DATA_WIDTH`: operand A; value shifted for sll/srl.
- `srcB` in `DATA_WIDTH`: operand B; for shifts only bits `[SHAMT_W-1:0]` used.
- `outValid` out 1: `aluResult`/`zero` valid.
- `outReady` in 1: downstream consumes result.
- `aluResult` out `DATA_WIDTH`: registered result.
- `zero` out 1: registered, 1 iff `aluResult == 0`.

## Operation
- States: IDLE, SHIFT, DONE. Reset → IDLE.
- Accept = `inValid & inReady`. `inReady = (state==IDLE) | (state==DONE & outReady)`; low in SHIFT.
- `aluControl`, `srcA`, `srcB` sampled only on accept; changes at other times ignored.
- Accept of non-shift op: result computed and registered, → DONE.
  - add/sub modulo 2^`DATA_WIDTH`, no overflow flag.
  - and/or bitwise.
  - slt signed, sltu unsigned compare; result is 1 or 0 zero-extended.
- Accept of sll/srl: shift register ← `srcA`, counter ← `srcB[SHAMT_W-1:0]`.
  - Counter 0: → DONE, result = `srcA`.
  - Otherwise → SHIFT; each cycle shift one bit (sll left, srl logical right, zero fill), counter −1; when counter reaches 0 after the shift → DONE.
  - No arithmetic right shift; the decoder emits no code for it.
- DONE: `outValid`=1; `aluResult`, `zero` held stable until `outReady`.
  - `outReady` without accept → IDLE, `outValid` 0 next cycle.
  - `outReady` with accept in the same cycle → new op starts directly (back-to-back, no bubble).
- `zero` updates only when `aluResult` is written. It is never combinational from inputs.

## Timing
- Reset values: `outValid`=0, `aluResult`=0, `zero`=0, state IDLE, counter 0. `inReady`=1 once `rst_n` deasserts.
- Reset asserted mid-SHIFT or in DONE: operation discarded and outputs take reset values immediately (asynchronous).
- Latency, accept edge to first cycle with `outValid`=1:
  - non-shift op, or shift with shamt 0: 1 cycle.
  - shift with shamt k>0: 1+k cycles. Worst case is `DATA_WIDTH` cycles.
- Throughput with `outReady` held high: one non-shift op per cycle.
- `outValid` never drops without `outReady`=1 in the preceding cycle.

## Configuration
- `ALU_FAST_SHIFT_EN` defined:
  - sll/srl use a single-cycle barrel shifter with 1-cycle latency for every op.
  - SHIFT state and counter are compiled out.
  - `inReady` = `(state==IDLE) | outReady`.
- `ALU_FAST_SHIFT_EN` undefined: iterative shifter as specified above.
- Results are identical in both builds; only latency differs.

## Test plan
- add `srcA`=5, `srcB`=7, `outReady`=1 → `aluResult`=12, `zero`=0, `outValid` exactly 1 cycle after accept.
- sub 3−5 → `aluResult`=0xFFFFFFFE. Next op sub 9−9, back-to-back → `aluResult`=0, `zero`=1, no idle cycle between results.
- slt `srcA`=0xFFFFFFFF, `srcB`=1 → 1. sltu with the same operands → 0.
- sll `srcA`=1, `srcB`=0x3F (shamt 31) → `aluResult`=0x80000000, `outValid` 32 cycles after accept, `inReady`=0 throughout. srl 0x80000000 by 0 → 0x80000000 after 1 cycle.
  - With `ALU_FAST_SHIFT_EN`: both shifts after 1 cycle, same results.
- Back-pressure: or 0xF0|0x0F with `outReady`=0 for 3 cycles → `aluResult`=0xFF held, `inReady`=0, input changes ignored. `outReady`=1 → consumed, `outValid`=0 next cycle.
- Assert `rst_n`=0 mid-way through an srl by 20 → `outValid`=0, `aluResult`=0, `zero`=0 at once. After release, add 1+1 → 2 with 1-cycle latency.
